// File: rtl/mat_unit_seq.sv
// Sequencer for the WIDTH x WIDTH systolic matrix unit: drives the weight-load
// sweep, then streams a counted batch of vectors and tags valid output cycles.
module mat_unit_seq #(
    parameter int unsigned WIDTH    = 128,
    parameter int unsigned PROG_W   = $clog2(3*WIDTH),
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned PIPE_LAT = 2*WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              stream_start,
    input  logic [LEN_W-1:0]  stream_len,
    output logic              cmd_err,
    output logic              busy,
    output logic              load_done,
    output logic              stream_done,
    output logic              w_req,
    output logic [PROG_W-1:0] w_row,
    output logic              mat_load_weight,
    output logic [PROG_W-1:0] mat_weight_prog,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mat_in_en,
    output logic              out_valid
);

    localparam int unsigned       LOAD_LEN  = 3*WIDTH - 2;
    localparam logic [PROG_W-1:0] PROG_LAST = PROG_W'(LOAD_LEN - 1);
    localparam logic [PROG_W-1:0] PROG_WREQ = PROG_W'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PROG_W-1:0]   r_prog, w_prog_nxt;
    logic [LEN_W-1:0]    r_rem, w_rem_nxt;
    logic [PIPE_LAT-1:0] r_dly, w_dly_nxt;
    logic                r_cmd_err, w_cmd_err_nxt;
    logic                r_load_done, w_load_done_nxt;
    logic                r_stream_done, w_stream_done_nxt;
    logic                w_loading, w_in_ready, w_accept, w_any_start;

    assign w_loading   = (r_state == ST_LOAD);
    assign w_in_ready  = (r_state == ST_STREAM) && (r_rem != '0);
    assign w_accept    = in_valid && w_in_ready;
    assign w_any_start = load_start || stream_start;

    // Valid-tag delay line mirrors the array latency; it never stalls.
    assign w_dly_nxt = (r_dly << 1) | PIPE_LAT'(w_accept);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_prog        <= '0;
            r_rem         <= '0;
            r_dly         <= '0;
            r_cmd_err     <= 1'b0;
            r_load_done   <= 1'b0;
            r_stream_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_prog        <= w_prog_nxt;
            r_rem         <= w_rem_nxt;
            r_dly         <= w_dly_nxt;
            r_cmd_err     <= w_cmd_err_nxt;
            r_load_done   <= w_load_done_nxt;
            r_stream_done <= w_stream_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_prog_nxt        = r_prog;
        w_rem_nxt         = r_rem;
        w_cmd_err_nxt     = 1'b0;
        w_load_done_nxt   = 1'b0;
        w_stream_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Load has priority; a simultaneous stream request is rejected.
                if (load_start) begin
                    w_state_nxt   = ST_LOAD;
                    w_prog_nxt    = '0;
                    w_cmd_err_nxt = stream_start;
                end else if (stream_start) begin
                    if (stream_len == '0) begin
                        w_stream_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_STREAM;
                        w_rem_nxt   = stream_len;
                    end
                end
            end
            ST_LOAD: begin
                w_cmd_err_nxt = w_any_start;
                if (r_prog == PROG_LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_prog_nxt      = '0;
                    w_load_done_nxt = 1'b1;
                end else begin
                    w_prog_nxt = r_prog + PROG_W'(1);
                end
            end
            ST_STREAM: begin
                w_cmd_err_nxt = w_any_start;
                if (w_accept) begin
                    w_rem_nxt = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                w_cmd_err_nxt = w_any_start;
                if (w_dly_nxt == '0) begin
                    w_state_nxt       = ST_IDLE;
                    w_stream_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign cmd_err         = r_cmd_err;
    assign load_done       = r_load_done;
    assign stream_done     = r_stream_done;
    assign busy            = (r_state != ST_IDLE);
    assign mat_load_weight = w_loading;
    assign mat_weight_prog = w_loading ? r_prog : '0;
    assign w_req           = w_loading && (r_prog < PROG_WREQ);
    assign w_row           = w_req ? r_prog : '0;
    assign in_ready        = w_in_ready;
    assign mat_in_en       = w_accept;
    assign out_valid       = r_dly[PIPE_LAT-1];

endmodule

// File: tb/tb_mat_unit_seq.sv
// Directed per-cycle vector bench for mat_unit_seq at WIDTH=4, PIPE_LAT=8.
module tb_mat_unit_seq;

    logic        clock;
    logic        reset;
    logic        load_start;
    logic        stream_start;
    logic [15:0] stream_len;
    logic        cmd_err;
    logic        busy;
    logic        load_done;
    logic        stream_done;
    logic        w_req;
    logic [3:0]  w_row;
    logic        mat_load_weight;
    logic [3:0]  mat_weight_prog;
    logic        in_valid;
    logic        in_ready;
    logic        mat_in_en;
    logic        out_valid;

    mat_unit_seq #(.WIDTH(4), .PIPE_LAT(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .load_start     (load_start),
        .stream_start   (stream_start),
        .stream_len     (stream_len),
        .cmd_err        (cmd_err),
        .busy           (busy),
        .load_done      (load_done),
        .stream_done    (stream_done),
        .w_req          (w_req),
        .w_row          (w_row),
        .mat_load_weight(mat_load_weight),
        .mat_weight_prog(mat_weight_prog),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .mat_in_en      (mat_in_en),
        .out_valid      (out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       ce;
        logic       bz;
        logic       ld;
        logic       sd;
        logic       wr;
        logic       ml;
        logic [3:0] pg;
        logic [3:0] row;
        logic       ir;
        logic       me;
        logic       ov;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        ls;
        logic        ss;
        logic [15:0] len;
        logic        iv;
        exp_t        e;
        string       tag;
    } vec_t;

    vec_t  tab[$];
    string cur_tag;
    int    errors = 0;
    int    checks = 0;

    function automatic exp_t E(logic ce, logic bz, logic ld, logic sd, logic wr,
                               logic ml, logic [3:0] pg, logic ir, logic me, logic ov);
        exp_t r;
        r.ce = ce; r.bz = bz; r.ld = ld; r.sd = sd; r.wr = wr; r.ml = ml;
        r.pg = pg; r.row = wr ? pg : 4'd0; r.ir = ir; r.me = me; r.ov = ov;
        return r;
    endfunction

    localparam exp_t Z  = '0;

    task automatic add(input int n, input logic rst, input logic ls, input logic ss,
                       input logic [15:0] len, input logic iv, input exp_t e);
        vec_t v;
        v.rst = rst; v.ls = ls; v.ss = ss; v.len = len; v.iv = iv; v.e = e; v.tag = cur_tag;
        for (int j = 0; j < n; j++) tab.push_back(v);
    endtask

    // Weight sweep: optional stream_start with load_start, a rejected
    // stream_start at progress rej_at, or a reset at progress rst_at.
    task automatic sweep(input bit both, input int rej_at, input int rst_at);
        add(1, 0, 1, both, 16'd7, 0, Z);
        for (int k = 0; k < 10; k++) begin
            add(1, k == rst_at, 0, k == rej_at, 16'd5, 0,
                E((both && k == 0) || (k == rej_at + 1), 1, 0, 0, k < 4, 1, 4'(k), 0, 0, 0));
            if (k == rst_at) return;
        end
        add(1, 0, 0, 0, 16'd0, 0, E(0, 0, 1, 0, 0, 0, 4'd0, 0, 0, 0));
    endtask

    localparam exp_t BZ  = 17'b0_1_0_0_0_0_0000_0000_0_0_0;
    localparam exp_t BOV = 17'b0_1_0_0_0_0_0000_0000_0_0_1;
    localparam exp_t ACC = 17'b0_1_0_0_0_0_0000_0000_1_1_0;
    localparam exp_t BUB = 17'b0_1_0_0_0_0_0000_0000_1_0_0;
    localparam exp_t SD  = 17'b0_0_0_1_0_0_0000_0000_0_0_0;

    initial begin
        exp_t act;
        reset = 1'b1; load_start = 1'b0; stream_start = 1'b0;
        stream_len = 16'd0; in_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #2;
        checks++;
        if ({cmd_err, busy, load_done, stream_done, w_req, w_row, mat_load_weight,
             mat_weight_prog, in_ready, mat_in_en, out_valid} !== 17'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", {cmd_err, busy, load_done, stream_done,
                     w_req, w_row, mat_load_weight, mat_weight_prog, in_ready, mat_in_en, out_valid});
        end

        cur_tag = "load_rej_stream"; sweep(0, 2, 100); add(1, 0, 0, 0, 16'd0, 0, Z);
        cur_tag = "load_both";       sweep(1, 100, 100); add(1, 0, 0, 0, 16'd0, 0, Z);

        cur_tag = "stream_full";
        add(1, 0, 0, 1, 16'd3, 1, Z);
        add(1, 0, 1, 0, 16'd0, 1, ACC);
        add(1, 0, 0, 0, 16'd0, 1, E(1, 1, 0, 0, 0, 0, 4'd0, 1, 1, 0));
        add(1, 0, 0, 0, 16'd0, 1, ACC);
        add(1, 0, 0, 0, 16'd0, 1, BZ);
        add(1, 0, 0, 1, 16'd4, 1, BZ);
        add(1, 0, 0, 0, 16'd0, 1, E(1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 0));
        add(2, 0, 0, 0, 16'd0, 1, BZ);
        add(3, 0, 0, 0, 16'd0, 1, BOV);
        add(1, 0, 0, 0, 16'd0, 0, SD);
        add(1, 0, 0, 0, 16'd0, 0, Z);

        cur_tag = "stream_gaps";
        add(1, 0, 0, 1, 16'd3, 0, Z);
        add(1, 0, 0, 0, 16'd0, 1, ACC);
        add(1, 0, 0, 0, 16'd0, 0, BUB);
        add(1, 0, 0, 0, 16'd0, 1, ACC);
        add(1, 0, 0, 0, 16'd0, 0, BUB);
        add(1, 0, 0, 0, 16'd0, 1, ACC);
        add(3, 0, 0, 0, 16'd0, 0, BZ);
        add(1, 0, 0, 0, 16'd0, 0, BOV);
        add(1, 0, 0, 0, 16'd0, 0, BZ);
        add(1, 0, 0, 0, 16'd0, 0, BOV);
        add(1, 0, 0, 0, 16'd0, 0, BZ);
        add(1, 0, 0, 0, 16'd0, 0, BOV);
        add(1, 0, 0, 0, 16'd0, 0, SD);
        add(1, 0, 0, 0, 16'd0, 0, Z);

        cur_tag = "stream_len0";
        add(1, 0, 0, 1, 16'd0, 1, Z);
        add(1, 0, 0, 0, 16'd0, 1, SD);
        add(2, 0, 0, 0, 16'd0, 1, Z);

        cur_tag = "reset_in_load";
        sweep(0, 100, 5);
        add(4, 0, 0, 0, 16'd0, 0, Z);
        cur_tag = "load_after_rst";
        sweep(0, 100, 100);

        cur_tag = "reset_in_drain";
        add(1, 0, 0, 1, 16'd1, 1, Z);
        add(1, 0, 0, 0, 16'd0, 1, ACC);
        add(1, 0, 0, 0, 16'd0, 0, BZ);
        add(1, 1, 0, 0, 16'd0, 0, BZ);
        add(10, 0, 0, 0, 16'd0, 0, Z);
        cur_tag = "load_after_rst2";
        sweep(0, 100, 100);
        add(2, 0, 0, 0, 16'd0, 0, Z);

        foreach (tab[i]) begin
            @(negedge clock);
            reset        = tab[i].rst;
            load_start   = tab[i].ls;
            stream_start = tab[i].ss;
            stream_len   = tab[i].len;
            in_valid     = tab[i].iv;
            #2;
            act.ce  = cmd_err;
            act.bz  = busy;
            act.ld  = load_done;
            act.sd  = stream_done;
            act.wr  = w_req;
            act.ml  = mat_load_weight;
            act.pg  = tab[i].e.ml ? mat_weight_prog : 4'd0;
            act.row = tab[i].e.wr ? w_row : 4'd0;
            act.ir  = in_ready;
            act.me  = mat_in_en;
            act.ov  = out_valid;
            checks++;
            if (act !== tab[i].e) begin
                errors++;
                $display("FAIL row %0d (%s): got %b want %b", i, tab[i].tag, act, tab[i].e);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
